// File: rtl/doc_uart_sender.sv
// doc_uart_sender: streams a ROWS x COLS text document out of an 8N1 UART.
// Each row is sent as COLS characters followed by CR (0x0D) and LF (0x0A).
// NUL characters in the document are sent as spaces.
//
// Ports:
//   clk         system clock, all state on its rising edge
//   rst         asynchronous active-high reset
//   start       single-cycle request to send the whole document (IDLE only)
//   read_enable high while the block owns the document read port
//   read_addr   document address {row[3:0], col[4:0]}
//   read_data   document byte at read_addr (combinational read)
//   tx          UART serial line, idle high
//   busy        high from start acceptance until done
//   done        one-cycle pulse after the final stop bit
module doc_uart_sender #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ROWS         = 15,
    parameter int unsigned COLS         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       read_enable,
    output logic [8:0] read_addr,
    input  logic [7:0] read_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] RowLast = 4'(ROWS - 1);
    localparam logic [4:0] ColLast = 5'(COLS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStartBit,
        StDataBits,
        StStopBit,
        StFinish
    } state_e;

    // What the current slot of a row carries.
    typedef enum logic [1:0] {
        SlotChar,
        SlotCr,
        SlotLf
    } slot_e;

    state_e          state_q, state_d;
    slot_e           slot_q, slot_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [3:0]      row_q, row_d;
    logic [4:0]      col_q, col_d;
    logic [7:0]      byte_q, byte_d;

    logic bit_end;
    logic last_slot;

    assign bit_end   = (cnt_q == CntLast);
    assign last_slot = (slot_q == SlotLf) && (row_q == RowLast);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= SlotChar;
            cnt_q  <= '0;
            bit_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
            byte_q <= '0;
        end else begin
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            row_q  <= row_d;
            col_q  <= col_d;
            byte_q <= byte_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        row_d   = row_q;
        col_d   = col_q;
        byte_d  = byte_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    slot_d  = SlotChar;
                    cnt_d   = '0;
                    bit_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end

            StFetch: begin
                unique case (slot_q)
                    SlotCr:  byte_d = 8'h0D;
                    SlotLf:  byte_d = 8'h0A;
                    default: byte_d = (read_data == 8'h00) ? 8'h20 : read_data;
                endcase
                cnt_d   = '0;
                state_d = StStartBit;
            end

            StStartBit: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StDataBits;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StDataBits: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStopBit;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StStopBit: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (last_slot) begin
                        state_d = StFinish;
                    end else begin
                        state_d = StFetch;
                        unique case (slot_q)
                            SlotCr: slot_d = SlotLf;
                            SlotLf: begin
                                slot_d = SlotChar;
                                row_d  = row_q + 4'd1;
                                col_d  = '0;
                            end
                            default: begin
                                // CR/LF keep col at the last column so the address stays in range.
                                if (col_q == ColLast) begin
                                    slot_d = SlotCr;
                                end else begin
                                    col_d = col_q + 5'd1;
                                end
                            end
                        endcase
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StFinish: begin
                // A start seen here is dropped; only IDLE accepts a request.
                state_d = StIdle;
                slot_d  = SlotChar;
                bit_d   = '0;
                row_d   = '0;
                col_d   = '0;
            end

            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        tx          = 1'b1;
        busy        = 1'b0;
        read_enable = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            StFetch: begin
                busy        = 1'b1;
                read_enable = 1'b1;
            end
            StStartBit: begin
                busy        = 1'b1;
                read_enable = 1'b1;
                tx          = 1'b0;
            end
            StDataBits: begin
                busy        = 1'b1;
                read_enable = 1'b1;
                tx          = byte_q[bit_q];
            end
            StStopBit: begin
                busy        = 1'b1;
                read_enable = 1'b1;
            end
            StFinish: done = 1'b1;
            default: ;
        endcase
    end

    assign read_addr = {row_q, col_q};

endmodule

// File: tb/tb_doc_uart_sender.sv
module tb_doc_uart_sender;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic       re_a, re_b, re_c;
    logic [8:0] ra_a, ra_b, ra_c;
    logic [7:0] rd_a, rd_b, rd_c;
    logic       tx_a, tx_b, tx_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;

    logic [7:0] mem [0:511];
    assign rd_a = mem[ra_a];
    assign rd_b = mem[ra_b];
    assign rd_c = mem[ra_c];

    // a: 1x1 doc, b: 2x3 doc, c: default parameters
    doc_uart_sender #(.CLKS_PER_BIT(4), .ROWS(1), .COLS(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .read_enable(re_a), .read_addr(ra_a),
        .read_data(rd_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );
    doc_uart_sender #(.CLKS_PER_BIT(4), .ROWS(2), .COLS(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .read_enable(re_b), .read_addr(ra_b),
        .read_data(rd_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );
    doc_uart_sender u_c (
        .clk(clk), .rst(rst), .start(start_c), .read_enable(re_c), .read_addr(ra_c),
        .read_data(rd_c), .tx(tx_c), .busy(busy_c), .done(done_c)
    );

    typedef struct {
        logic [7:0] data;
        logic [8:0] addr;
        bit         is_char;
    } vec_t;

    vec_t tbl_b [10];
    vec_t cur [10];

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;

    always @(negedge clk) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (done_c) done_cnt_c <= done_cnt_c + 1;
    end

    function automatic logic tx_of(input int w);
        return (w == 0) ? tx_a : (w == 1) ? tx_b : tx_c;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 0) ? busy_a : (w == 1) ? busy_b : busy_c;
    endfunction
    function automatic logic re_of(input int w);
        return (w == 0) ? re_a : (w == 1) ? re_b : re_c;
    endfunction
    function automatic logic done_of(input int w);
        return (w == 0) ? done_a : (w == 1) ? done_b : done_c;
    endfunction
    function automatic logic [8:0] addr_of(input int w);
        return (w == 0) ? ra_a : (w == 1) ? ra_b : ra_c;
    endfunction
    function automatic int done_cnt_of(input int w);
        return (w == 0) ? done_cnt_a : (w == 1) ? done_cnt_b : done_cnt_c;
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Start is sampled at one rising edge; the following cycle must be FETCH.
    task automatic pulse_start(input int w, input string name);
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
        chk({name, " fetch busy"}, 32'(busy_of(w)), 32'd1);
        chk({name, " fetch read_enable"}, 32'(re_of(w)), 32'd1);
        chk({name, " fetch read_addr"}, 32'(addr_of(w)), 32'h0);
    endtask

    // Waits for a start bit; gap counts idle-high cycles seen first.
    task automatic wait_fall(input int w, output int gap, output bit ok);
        gap = 0;
        ok  = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tx_of(w) == 1'b0) begin
                ok = 1'b1;
                break;
            end
            gap++;
        end
    endtask

    // Checks a whole frame cycle by cycle, plus the one-cycle inter-frame gap.
    // poke=1 pulses a second start in the middle of the data bits.
    task automatic check_frame(input int w, input int cpb, input logic [7:0] b,
                               input logic [8:0] addr, input bit chk_addr, input bit poke,
                               input string name);
        int   gap;
        bit   ok;
        bit   bad;
        int   bad_i;
        logic bad_act, bad_exp;
        logic exp_tx;
        int   j;
        wait_fall(w, gap, ok);
        if (!ok) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL %s: no start bit within 50 cycles", name);
            return;
        end
        chk({name, " gap"}, 32'(gap), 32'd1);
        if (chk_addr) chk({name, " read_addr"}, 32'(addr_of(w)), 32'(addr));
        bad = 1'b0;
        bad_i = 0;
        bad_act = 1'b0;
        bad_exp = 1'b0;
        for (int i = 0; i < 10 * cpb; i++) begin
            if (i > 0) @(negedge clk);
            if (poke && i == 5 * cpb) set_start(w, 1'b1);
            if (poke && i == 5 * cpb + 2) set_start(w, 1'b0);
            j = i / cpb;
            exp_tx = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j-1];
            if (!bad && (tx_of(w) !== exp_tx || busy_of(w) !== 1'b1 || re_of(w) !== 1'b1
                         || (chk_addr && addr_of(w) !== addr))) begin
                bad = 1'b1;
                bad_i = i;
                bad_act = tx_of(w);
                bad_exp = exp_tx;
            end
        end
        vec_cnt++;
        if (bad) begin
            miss_cnt++;
            $display("FAIL %s frame: cycle %0d tx=%0b busy=%0b re=%0b addr=0x%0h, expected tx=%0b",
                     name, bad_i, bad_act, busy_of(w), re_of(w), addr_of(w), bad_exp);
        end
    endtask

    task automatic run_stream(input int w, input int n, input int poke_frame,
                              input bit start_in_finish, input string name);
        int d0;
        d0 = done_cnt_of(w);
        pulse_start(w, name);
        for (int f = 0; f < n; f++) begin
            check_frame(w, 4, cur[f].data, cur[f].addr, cur[f].is_char, f == poke_frame,
                        $sformatf("%s byte%0d", name, f));
        end
        @(negedge clk);
        chk({name, " finish done"}, 32'(done_of(w)), 32'd1);
        chk({name, " finish busy"}, 32'(busy_of(w)), 32'd0);
        chk({name, " finish read_enable"}, 32'(re_of(w)), 32'd0);
        if (start_in_finish) set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        chk({name, " idle done"}, 32'(done_of(w)), 32'd0);
        begin
            bit active;
            active = 1'b0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (busy_of(w) || !tx_of(w)) active = 1'b1;
            end
            chk({name, " stays idle"}, 32'(active), 32'd0);
        end
        chk({name, " done count"}, 32'(done_cnt_of(w) - d0), 32'd1);
    endtask

    initial begin
        tbl_b[0] = '{8'h30, 9'h000, 1'b1};
        tbl_b[1] = '{8'h31, 9'h001, 1'b1};
        tbl_b[2] = '{8'h32, 9'h002, 1'b1};
        tbl_b[3] = '{8'h0D, 9'h000, 1'b0};
        tbl_b[4] = '{8'h0A, 9'h000, 1'b0};
        tbl_b[5] = '{8'h33, 9'h020, 1'b1};
        tbl_b[6] = '{8'h34, 9'h021, 1'b1};
        tbl_b[7] = '{8'h35, 9'h022, 1'b1};
        tbl_b[8] = '{8'h0D, 9'h000, 1'b0};
        tbl_b[9] = '{8'h0A, 9'h000, 1'b0};
        for (int k = 0; k < 512; k++) mem[k] = 8'hFF;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset tx", 32'(tx_b), 32'd1);
        chk("reset busy", 32'(busy_b), 32'd0);
        chk("reset done", 32'(done_b), 32'd0);
        chk("reset read_enable", 32'(re_b), 32'd0);
        chk("reset read_addr", 32'(ra_b), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1x1 document: 'A', CR, LF
        mem[0] = 8'h41;
        cur[0] = '{8'h41, 9'h000, 1'b1};
        cur[1] = '{8'h0D, 9'h000, 1'b0};
        cur[2] = '{8'h0A, 9'h000, 1'b0};
        run_stream(0, 3, -1, 1'b0, "a41");

        // NUL is sent as space
        mem[0] = 8'h00;
        cur[0] = '{8'h20, 9'h000, 1'b1};
        run_stream(0, 3, -1, 1'b0, "anul");

        // 2x3 document, start also raised during FINISH
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                mem[r * 32 + c] = 8'(8'h30 + 3 * r + c);
        for (int k = 0; k < 10; k++) cur[k] = tbl_b[k];
        run_stream(1, 10, -1, 1'b1, "b");

        // Second start mid-transmission is ignored
        run_stream(1, 10, 2, 1'b0, "bpoke");

        // Reset during data bits of byte 2 aborts without done
        begin
            int gap;
            bit ok;
            int d0;
            d0 = done_cnt_b;
            pulse_start(1, "brst");
            check_frame(1, 4, 8'h30, 9'h000, 1'b1, 1'b0, "brst byte0");
            wait_fall(1, gap, ok);
            chk("brst byte1 seen", 32'(ok), 32'd1);
            repeat (20) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            chk("brst tx", 32'(tx_b), 32'd1);
            chk("brst busy", 32'(busy_b), 32'd0);
            chk("brst read_enable", 32'(re_b), 32'd0);
            chk("brst read_addr", 32'(ra_b), 32'h0);
            @(negedge clk);
            rst = 1'b0;
            repeat (30) @(negedge clk);
            chk("brst no done", 32'(done_cnt_b - d0), 32'd0);
            chk("brst idle busy", 32'(busy_b), 32'd0);
            run_stream(1, 10, -1, 1'b0, "bafter");
        end

        // Default parameters: first frame timing only
        mem[0] = 8'h55;
        pulse_start(2, "c");
        check_frame(2, 868, 8'h55, 9'h000, 1'b1, 1'b0, "c byte0");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("c abort no done", 32'(done_cnt_c), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
